// File: rtl/song_sequencer.sv
// song_sequencer: steps a song table and emits merged note-on/note-off events on a valid/ready port
module song_sequencer #(
  parameter int NUM_STEPS       = 160,
  parameter int NOTE_W          = 5,
  parameter int CYCLES_PER_STEP = 12_500_000
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [NUM_STEPS-1:0][NOTE_W:0]   song_in,
  input  logic [7:0]                       song_len_in,
  input  logic                             start_in,
  input  logic                             stop_in,
  input  logic                             loop_in,
  input  logic                             note_ready_in,
  output logic                             note_valid_out,
  output logic                             note_on_out,
  output logic [NOTE_W-1:0]                note_out,
  output logic [7:0]                       step_out,
  output logic [NOTE_W:0]                  cur_note_out,
  output logic                             busy_out,
  output logic                             done_out
);
  localparam int TW = $clog2(CYCLES_PER_STEP);
  localparam logic [TW-1:0] T_END = TW'(CYCLES_PER_STEP - 1);
  typedef enum logic [2:0] {IDLE, FETCH, EMIT_OFF, EMIT_ON, HOLD, FINAL_OFF} state_t;
  state_t            state_q, state_d;
  logic [7:0]        step_q, step_d, len_q, len_d, len_eff;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NOTE_W:0]   cur_q, cur_d, slot;
  logic [NOTE_W-1:0] note_q, note_d, nxt_q, nxt_d;
  logic              valid_q, valid_d, on_q, on_d, pend_q, pend_d;
  logic              stop_q, stop_d, done_q, done_d;
  logic              stop_eff, acc, fin, nat;
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    cur_d    = cur_q;
    note_d   = note_q;
    nxt_d    = nxt_q;
    valid_d  = valid_q;
    on_d     = on_q;
    pend_d   = pend_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    nat      = 1'b0;
    slot     = song_in[step_q];
    len_eff  = song_len_in > 8'(NUM_STEPS) ? 8'(NUM_STEPS) : song_len_in;
    stop_eff = stop_in | stop_q;
    acc      = valid_q & note_ready_in;
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start_in && !stop_in) begin
          len_d = len_eff;
          if (len_eff == 8'd0) done_d = 1'b1;
          else begin
            state_d = FETCH;
            step_d  = 8'd0;
          end
        end
      end
      FETCH: begin
        if (stop_eff) begin
          stop_d = 1'b1;
          fin    = 1'b1;
        end else if (slot[NOTE_W] && !cur_q[NOTE_W]) begin
          state_d = EMIT_ON;
          valid_d = 1'b1;
          on_d    = 1'b1;
          note_d  = slot[NOTE_W-1:0];
        end else if (cur_q[NOTE_W] && slot != cur_q) begin
          // a different note (or a rest) releases the held note first
          state_d = EMIT_OFF;
          valid_d = 1'b1;
          on_d    = 1'b0;
          note_d  = cur_q[NOTE_W-1:0];
          pend_d  = slot[NOTE_W];
          nxt_d   = slot[NOTE_W-1:0];
        end else state_d = HOLD;
      end
      EMIT_OFF: begin
        stop_d = stop_eff;
        if (acc) begin
          cur_d = '0;
          if (stop_eff) fin = 1'b1;
          else if (pend_q) begin
            state_d = EMIT_ON;
            on_d    = 1'b1;
            note_d  = nxt_q;
            pend_d  = 1'b0;
          end else begin
            state_d = HOLD;
            valid_d = 1'b0;
          end
        end
      end
      EMIT_ON: begin
        stop_d = stop_eff;
        if (acc) begin
          cur_d   = {1'b1, note_q};
          valid_d = 1'b0;
          if (stop_eff) fin = 1'b1;
          else state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop_eff) begin
          stop_d = 1'b1;
          fin    = 1'b1;
        end else if (timer_q == T_END) begin
          if (step_q < len_q - 8'd1) begin
            state_d = FETCH;
            step_d  = step_q + 8'd1;
          end else if (loop_in) begin
            state_d = FETCH;
            step_d  = 8'd0;
          end else begin
            fin = 1'b1;
            nat = 1'b1;
          end
        end
      end
      FINAL_OFF: begin
        if (acc) begin
          state_d = IDLE;
          cur_d   = '0;
          valid_d = 1'b0;
          done_d  = ~stop_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = cur_d[NOTE_W] ? FINAL_OFF : IDLE;
      valid_d = cur_d[NOTE_W];
      on_d    = 1'b0;
      note_d  = cur_d[NOTE_W-1:0];
      pend_d  = 1'b0;
      done_d  = nat & ~cur_d[NOTE_W];
    end
    timer_d = state_d == FETCH ? '0 : (timer_q == T_END ? timer_q : timer_q + TW'(1));
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= '0;
      timer_q <= '0;
      cur_q   <= '0;
      note_q  <= '0;
      nxt_q   <= '0;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      pend_q  <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
      note_q  <= note_d;
      nxt_q   <= nxt_d;
      valid_q <= valid_d;
      on_q    <= on_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end
  assign note_valid_out = valid_q;
  assign note_on_out    = on_q;
  assign note_out       = note_q;
  assign step_out       = step_q;
  assign cur_note_out   = cur_q;
  assign busy_out       = state_q != IDLE;
  assign done_out       = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench for song_sequencer with a 4-cycle step
module tb_song_sequencer;
  localparam int NS = 160, NW = 5, CPS = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0, ready = 1'b1;
  logic [NS-1:0][NW:0] song;
  logic [7:0] len;
  logic valid, on, busy, done;
  logic [NW-1:0] note;
  logic [7:0] step;
  logic [NW:0] cur;
  logic [22:0] outs;
  int n_chk = 0, n_fail = 0, cyc_n = 0, evt_cnt = 0;
  logic [14:0] exp_q[$];
  logic [NW:0] cur_q[$];
  bit cur_chk = 1'b0;
  logic [7:0] prev_step = 8'd0;
  logic prev_busy = 1'b0;
  song_sequencer #(.NUM_STEPS(NS), .NOTE_W(NW), .CYCLES_PER_STEP(CPS)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .song_in(song), .song_len_in(len),
    .start_in(start), .stop_in(stop), .loop_in(loop), .note_ready_in(ready),
    .note_valid_out(valid), .note_on_out(on), .note_out(note), .step_out(step),
    .cur_note_out(cur), .busy_out(busy), .done_out(done)
  );
  assign outs = {valid, on, note, step, cur, busy, done};
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic void push(input int s, input bit o, input logic [NW-1:0] n);
    exp_q.push_back({1'b0, 8'(s), o, n});
  endfunction
  task automatic model(input int l);
    int lim;
    logic [NW:0] c, s;
    lim = l > NS ? NS : l;
    c = '0;
    for (int i = 0; i < lim; i++) begin
      s = song[i];
      if (s[NW]) begin
        if (!c[NW]) push(i, 1'b1, s[NW-1:0]);
        else if (c[NW-1:0] != s[NW-1:0]) begin
          push(i, 1'b0, c[NW-1:0]);
          push(i, 1'b1, s[NW-1:0]);
        end
        c = s;
      end else if (c[NW]) begin
        push(i, 1'b0, c[NW-1:0]);
        c = '0;
      end
      if (cur_chk && i < lim - 1) cur_q.push_back(c);
    end
    if (c[NW]) push(lim - 1, 1'b0, c[NW-1:0]);
  endtask
  // every accepted event is consumed against the scoreboard; held notes checked at each step boundary
  always @(negedge clk) begin
    if (valid && ready) begin
      evt_cnt <= evt_cnt + 1;
      chk("evt_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("evt", {on, note}, e[5:0]);
        if (!e[14]) chk("evt_step", step, e[13:6]);
      end
    end
    if (cur_chk && busy && prev_busy && step != prev_step) begin
      chk("cur_avail", cur_q.size() != 0, 1);
      if (cur_q.size() != 0) chk("cur_note", cur, cur_q.pop_front());
    end
    prev_step <= step;
    prev_busy <= busy;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic set_basic();
    song = '0;
    song[1] = 6'b1_00010;
    song[2] = 6'b1_00010;
    song[3] = 6'b1_00101;
  endtask
  task automatic gen_song();
    logic [NW-1:0] last;
    int r;
    last = 5'd3;
    for (int i = 0; i < NS; i++) begin
      r = $urandom_range(0, 7);
      if (r < 2) song[i] = '0;
      else if (r < 5) song[i] = {1'b1, last};
      else begin
        last = 5'($urandom_range(0, 31));
        song[i] = {1'b1, last};
      end
    end
  endtask
  task automatic run_to_done(input string tag, input int max, input bit gap_chk, input bit rnd,
                             output int t_done, output int steps);
    int last_t;
    logic [7:0] last_s;
    bit seen;
    last_t = cyc_n;
    last_s = 8'd0;
    seen = 1'b0;
    steps = 0;
    t_done = -1;
    for (int i = 0; i < max && !seen; i++) begin
      cyc(1);
      ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (busy && step != last_s) begin
        if (gap_chk) chk({tag, "_gap"}, cyc_n - last_t, CPS);
        last_s = step;
        last_t = cyc_n;
        steps++;
      end
      if (done) begin
        seen = 1'b1;
        t_done = cyc_n;
      end
    end
    ready = 1'b1;
    chk({tag, "_done_seen"}, seen, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, t3, td, ns, e0, ds, bs, wraps;
    bit stalled, found;
    logic [7:0] ls;
    song = '0;
    len = 8'd0;
    cyc(1);
    chk("reset_outs", outs, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    set_basic();
    len = 8'd4;
    model(4);
    pulse_start();
    t0 = cyc_n;
    run_to_done("t1", 40, 1'b1, 1'b0, td, ns);
    chk("t1_done_t", td - t0, 17);
    chk("t1_steps", ns, 3);
    cyc(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", {busy, cur}, 0);
    chk("t1_q", exp_q.size(), 0);
    model(4);
    pulse_start();
    t3 = -1;
    td = -1;
    stalled = 1'b0;
    for (int i = 0; i < 60 && td < 0; i++) begin
      cyc(1);
      if (step == 8'd3 && t3 < 0) t3 = cyc_n;
      if (!stalled && valid && !on && note == 5'd2) begin
        stalled = 1'b1;
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          chk("t2_hold", {valid, on, note, step}, {1'b1, 1'b0, 5'd2, 8'd3});
          cyc(1);
        end
        ready = 1'b1;
      end
      if (done) td = cyc_n;
    end
    chk("t2_stall_seen", stalled, 1);
    chk("t2_step3_len", td - t3, 15);
    chk("t2_q", exp_q.size(), 0);
    song = '0;
    song[0] = 6'b1_00010;
    song[1] = 6'b1_00010;
    len = 8'd2;
    loop = 1'b1;
    push(0, 1'b1, 5'd2);
    e0 = evt_cnt;
    pulse_start();
    wraps = 0;
    ds = 0;
    ls = 8'd0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (ls == 8'd1 && step == 8'd0) wraps++;
      ls = step;
      ds += int'(done);
    end
    chk("t3_wraps", wraps, 3);
    chk("t3_one_on", evt_cnt - e0, 1);
    chk("t3_playing", {busy, cur}, {1'b1, 6'b1_00010});
    exp_q.push_back({1'b1, 8'd0, 1'b0, 5'd2});
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      cyc(1);
      ds += int'(done);
    end
    chk("t3_stopped", {busy, cur}, 0);
    chk("t3_no_done", ds, 0);
    chk("t3_evts", evt_cnt - e0, 2);
    chk("t3_q", exp_q.size(), 0);
    loop = 1'b0;
    set_basic();
    len = 8'd4;
    model(4);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (valid && on && note == 5'd5) begin
        found = 1'b1;
        ready = 1'b0;
      end
    end
    chk("t4_on5_seen", found, 1);
    #1 rst_n = 1'b0;
    #1 chk("t4_async_rst", outs, 0);
    exp_q.delete();
    e0 = evt_cnt;
    cyc(2);
    rst_n = 1'b1;
    ready = 1'b1;
    cyc(10);
    chk("t4_no_evt", evt_cnt - e0, 0);
    chk("t4_idle", busy, 0);
    model(4);
    pulse_start();
    t0 = cyc_n;
    run_to_done("t4", 40, 1'b1, 1'b0, td, ns);
    chk("t4_replay_t", td - t0, 17);
    chk("t4_q", exp_q.size(), 0);
    e0 = evt_cnt;
    len = 8'd0;
    pulse_start();
    ds = int'(done);
    bs = int'(busy);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      ds += int'(done);
      bs += int'(busy);
    end
    chk("t5_len0_done", ds, 1);
    chk("t5_len0_busy", bs, 0);
    chk("t5_len0_evt", evt_cnt - e0, 0);
    len = 8'd4;
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    bs = int'(busy) + int'(done);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      bs += int'(busy) + int'(done);
    end
    chk("t5_start_stop", bs, 0);
    chk("t5_ss_evt", evt_cnt - e0, 0);
    model(4);
    pulse_start();
    t0 = cyc_n;
    cyc(5);
    pulse_start();
    run_to_done("t5_busy_start", 40, 1'b0, 1'b0, td, ns);
    chk("t5_busy_start_t", td - t0, 17);
    chk("t5_busy_start_q", exp_q.size(), 0);
    gen_song();
    len = 8'd200;
    model(200);
    pulse_start();
    run_to_done("t5_long", 1500, 1'b1, 1'b0, td, ns);
    chk("t5_long_steps", ns, 159);
    chk("t5_long_last", step, 159);
    chk("t5_long_q", exp_q.size(), 0);
    gen_song();
    song[20] = 6'b1_00000;
    song[21] = 6'b0_00000;
    len = 8'd160;
    cur_chk = 1'b1;
    model(160);
    pulse_start();
    run_to_done("t6", 4000, 1'b0, 1'b1, td, ns);
    chk("t6_steps", ns, 159);
    chk("t6_q", exp_q.size(), 0);
    chk("t6_cur_q", cur_q.size(), 0);
    cur_chk = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
